// File: rtl/dual_port_rw.sv
// Simple dual-port register file: one write port, one registered read port, shared clock.
// Synchronous active-low reset clears every word and the read register; same-address collisions are write-first.
module dual_port_rw #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_address,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              collision;

    assign collision = write_en && (write_address == read_address);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en) begin
            mem[write_address] <= data_in;
        end
    end

    // Forward the incoming word on a same-address hit so the read sees the new value this edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out <= '0;
        end else if (read_en) begin
            data_out <= collision ? data_in : mem[read_address];
        end
    end

endmodule

// File: tb/tb_dual_port_rw.sv
// Scoreboard bench for dual_port_rw: stimulus pushes the expected data_out per edge,
// an independent monitor pops and compares one value after every rising edge.
module tb_dual_port_rw;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk;
    logic              rst;
    logic              write_en;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] data_in;
    logic              read_en;
    logic [ADDR_W-1:0] read_address;
    logic [DATA_W-1:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;
    int step_no  = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] ref_out;

    typedef struct {
        logic [DATA_W-1:0] value;
        int                step;
    } exp_t;
    exp_t exp_q[$];

    dual_port_rw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .write_en      (write_en),
        .write_address (write_address),
        .data_in       (data_in),
        .read_en       (read_en),
        .read_address  (read_address),
        .data_out      (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: memory is an array of words, the read port is "last value read".
    task automatic model_edge(input logic r, input logic we, input logic [ADDR_W-1:0] wa,
                              input logic [DATA_W-1:0] d, input logic re,
                              input logic [ADDR_W-1:0] ra);
        exp_t e;
        if (!r) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            ref_out = '0;
        end else begin
            if (we) ref_mem[wa] = d;
            // write-first: the stored array already holds the new word when the read looks
            if (re) ref_out = ref_mem[ra];
        end
        step_no++;
        e.value = ref_out;
        e.step  = step_no;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic we, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] d, input logic re,
                        input logic [ADDR_W-1:0] ra);
        @(negedge clk);
        rst = r; write_en = we; write_address = wa; data_in = d;
        read_en = re; read_address = ra;
        model_edge(r, we, wa, d, re, ra);
    endtask

    // rst pulses low between edges only; must not reset anything.
    task automatic glitch_step(input logic we, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] d, input logic re,
                               input logic [ADDR_W-1:0] ra);
        @(negedge clk);
        rst = 1'b0; write_en = we; write_address = wa; data_in = d;
        read_en = re; read_address = ra;
        #2 rst = 1'b1;
        model_edge(1'b1, we, wa, d, re, ra);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (data_out !== e.value) begin
                    n_fail++;
                    $display("FAIL data_out step %0d: got %h expected %h", e.step, data_out, e.value);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b0; write_en = 1'b0; write_address = '0; data_in = '0;
        read_en = 1'b0; read_address = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_out = '0;

        // 1: reset, then read every address -> 0
        step(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd1);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd0);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd3);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2);
        // 2: write then read, then hold with read_en low
        step(1'b1, 1'b1, 2'd2, 4'h4, 1'b0, 2'd0);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 2'd1);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 2'd3);
        // 3: same-address collision, write-first
        step(1'b1, 1'b1, 2'd0, 4'h8, 1'b1, 2'd0);
        // 4: disabled write is ignored; different-address read returns old value
        step(1'b1, 1'b0, 2'd3, 4'hF, 1'b0, 2'd0);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd3);
        step(1'b1, 1'b1, 2'd0, 4'hE, 1'b1, 2'd1);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd0);
        // 5: overwrite with zeros
        step(1'b1, 1'b1, 2'd1, 4'h0, 1'b0, 2'd0);
        step(1'b1, 1'b1, 2'd2, 4'h0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd1);
        // 6: reset beats a concurrent write
        step(1'b1, 1'b1, 2'd2, 4'h4, 1'b1, 2'd2);
        step(1'b0, 1'b1, 2'd2, 4'h5, 1'b1, 2'd2);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2);
        // rst low between edges only has no effect
        step(1'b1, 1'b1, 2'd3, 4'h9, 1'b0, 2'd0);
        glitch_step(1'b1, 2'd1, 4'h6, 1'b1, 2'd3);
        step(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd1);

        // randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) != 0), 1'($urandom), ADDR_W'($urandom),
                 DATA_W'($urandom), 1'($urandom), ADDR_W'($urandom));
        end

        // bounded drain of the scoreboard
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
